// File: rtl/reg_dump_tx_pkg.sv
// Shared types and constants for the register-dump UART reader.
package reg_dump_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int FRAME_BITS      = 10;
  localparam int BYTES_PER_WORD  = 4;
  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_CLK_DIV = 868;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter. Accepts a new byte in the last cycle of the
// previous stop bit so consecutive frames run with no idle gap.
module uart_tx_byte
  import reg_dump_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  logic                  active_reg;
  logic [TW-1:0]         timer_reg;
  logic [3:0]            bit_idx_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  bit_end;

  assign bit_end = (timer_reg == TIMER_MAX);
  assign ready   = !active_reg || (bit_end && (bit_idx_reg == LAST_BIT));
  // Line level is the frame LSB; an all-ones shifter idles the line high.
  assign tx      = shift_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg  <= 1'b0;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '1;
    end else if (valid && ready) begin
      active_reg  <= 1'b1;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= {1'b1, data, 1'b0};
    end else if (active_reg) begin
      if (bit_end) begin
        timer_reg <= '0;
        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
        if (bit_idx_reg == LAST_BIT) begin
          active_reg  <= 1'b0;
          bit_idx_reg <= '0;
        end else begin
          bit_idx_reg <= bit_idx_reg + 4'd1;
        end
      end else begin
        timer_reg <= timer_reg + TW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Sweeps the register file debug port and streams every word as four
// little-endian UART bytes.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int CLK_DIV  = DEFAULT_CLK_DIV,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] debug_reg,
  output logic [4:0]  debug_reg_addr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t         state_reg, state_next;
  logic [4:0]     addr_reg, addr_next;
  logic [31:0]    word_reg, word_next;
  logic [1:0]     byte_idx_reg, byte_idx_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic           uart_valid, uart_ready;
  logic [DATA_BITS-1:0] uart_data;
  logic [1:0]     next_byte;

  assign next_byte      = byte_idx_reg + 2'd1;
  assign debug_reg_addr = addr_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      word_reg     <= word_next;
      byte_idx_reg <= byte_idx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // byte_idx_reg names the byte currently on the line; byte 0 is handed to
  // the transmitter straight from debug_reg in the same cycle it is latched.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    word_next     = word_reg;
    byte_idx_next = byte_idx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    uart_valid    = 1'b0;
    uart_data     = word_reg[{next_byte, 3'b000} +: DATA_BITS];
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          addr_next  = '0;
          busy_next  = 1'b1;
        end
      end
      LOAD: begin
        word_next     = debug_reg;
        byte_idx_next = '0;
        uart_valid    = 1'b1;
        uart_data     = debug_reg[DATA_BITS-1:0];
        state_next    = SEND;
      end
      SEND: begin
        if (uart_ready) begin
          if (byte_idx_reg != LAST_BYTE) begin
            uart_valid    = 1'b1;
            byte_idx_next = next_byte;
          end else if (addr_reg < LAST_ADDR) begin
            addr_next  = addr_reg + 5'd1;
            state_next = LOAD;
          end else begin
            addr_next  = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .valid(uart_valid),
    .data (uart_data),
    .ready(uart_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: decodes the UART stream and checks bytes,
// bit widths, busy length, done pulses, snapshot and reset behaviour.
module tb_reg_dump_tx;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic [31:0] dbg, dbg1;
  logic [4:0]  addr, addr1;
  logic        tx, busy, done, tx1, busy1, done1;
  logic [31:0] model_mem [32];

  always #5 clk = ~clk;

  assign dbg  = model_mem[addr];
  assign dbg1 = 32'hA5C3_0F81;

  reg_dump_tx #(.CLK_DIV(D), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .debug_reg(dbg),
    .debug_reg_addr(addr), .tx(tx), .busy(busy), .done(done)
  );

  reg_dump_tx #(.CLK_DIV(D), .NUM_REGS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .debug_reg(dbg1),
    .debug_reg_addr(addr1), .tx(tx1), .busy(busy1), .done(done1)
  );

  int n_vec = 0;
  int n_bad = 0;

  // UART decoders: every cycle of a bit must hold the level seen in its first cycle.
  logic [7:0] rx_q[$];
  logic [7:0] rx1_q[$];
  int rx_err = 0, rx1_err = 0, done_cnt = 0, done1_cnt = 0;
  int rx_cnt = 0, rx1_cnt = 0;
  bit rx_act = 0, rx1_act = 0;
  logic [9:0] rx_fr, rx1_fr;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rx_act = 0;
    end else begin
      if (done) done_cnt++;
      if (!rx_act && tx == 1'b0) begin
        rx_act = 1; rx_cnt = 0; rx_fr = '0;
      end
      if (rx_act) begin
        if (rx_cnt % D == 0) rx_fr[rx_cnt / D] = tx;
        else if (tx !== rx_fr[rx_cnt / D]) rx_err++;
        if (rx_cnt == 10 * D - 1) begin
          if (rx_fr[0] !== 1'b0 || rx_fr[9] !== 1'b1) rx_err++;
          rx_q.push_back(rx_fr[8:1]);
          rx_act = 0;
        end else begin
          rx_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      rx1_act = 0;
    end else begin
      if (done1) done1_cnt++;
      if (!rx1_act && tx1 == 1'b0) begin
        rx1_act = 1; rx1_cnt = 0; rx1_fr = '0;
      end
      if (rx1_act) begin
        if (rx1_cnt % D == 0) rx1_fr[rx1_cnt / D] = tx1;
        else if (tx1 !== rx1_fr[rx1_cnt / D]) rx1_err++;
        if (rx1_cnt == 10 * D - 1) begin
          if (rx1_fr[0] !== 1'b0 || rx1_fr[9] !== 1'b1) rx1_err++;
          rx1_q.push_back(rx1_fr[8:1]);
          rx1_act = 0;
        end else begin
          rx1_cnt++;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    return (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
  endfunction

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_addr(input logic [4:0] a, input int limit);
    int n = 0;
    while (addr != a && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic check_sweep(input string tag, input logic [31:0] w3);
    logic [31:0] w;
    check_val({tag, "_nbytes"}, rx_q.size(), 128);
    if (rx_q.size() == 128) begin
      for (int k = 0; k < 32; k++) begin
        w = {rx_q[4*k+3], rx_q[4*k+2], rx_q[4*k+1], rx_q[4*k]};
        check_val($sformatf("%s_word%0d", tag, k), w, (k == 3) ? w3 : exp_word(k));
      end
    end
    $display("dump %s: %0d bytes received", tag, rx_q.size());
  endtask

  initial begin
    int n, d0, diffs;
    logic [7:0] first_q[$];

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    for (int k = 0; k < 32; k++) model_mem[k] = exp_word(k);
    repeat (3) tick();
    check_val("reset_outs", 32'({tx, busy, done, addr}), 32'h80);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      tick();
      check_val("idle_outs", 32'({tx, busy, done, addr}), 32'h80);
    end
    $display("idle: 100 cycles observed");

    // Single word on the one-register instance.
    d0 = done1_cnt;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 1000) begin
      n++;
      tick();
    end
    check_val("single_busy_len", n, 161);
    check_val("single_done_hi", done1, 1);
    tick();
    check_val("single_done_lo", done1, 0);
    check_val("single_done_cnt", done1_cnt - d0, 1);
    check_val("single_nbytes", rx1_q.size(), 4);
    if (rx1_q.size() == 4) begin
      check_val("single_b0", rx1_q[0], 32'h81);
      check_val("single_b1", rx1_q[1], 32'h0F);
      check_val("single_b2", rx1_q[2], 32'hC3);
      check_val("single_b3", rx1_q[3], 32'hA5);
    end
    check_val("single_bit_err", rx1_err, 0);
    $display("single: busy %0d cycles, %0d bytes", n, rx1_q.size());

    // Full sweep.
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_idle(6000, n);
    check_val("sweep_busy_len", n, 5152);
    check_val("sweep_done_hi", done, 1);
    tick();
    check_sweep("sweep", exp_word(3));
    check_val("sweep_done_cnt", done_cnt - d0, 1);

    // Snapshot of word 3 and start ignored while busy.
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_addr(5'd3, 2000);
    check_val("snap_reach_w3", addr, 3);
    repeat (10) tick();
    model_mem[3] = 32'hDEAD_BEEF;
    pulse_start();
    wait_idle(6000, n);
    check_val("snap_done_hi", done, 1);
    tick();
    check_sweep("snap", 32'h1000_0003);
    repeat (200) tick();
    check_val("snap_no_restart", busy, 0);
    check_val("snap_done_cnt", done_cnt - d0, 1);
    model_mem[3] = exp_word(3);

    // Asynchronous reset during a data bit of byte 2 of word 5 (byte value 0x00).
    rx_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_addr(5'd5, 2000);
    check_val("mid_reach_w5", addr, 5);
    repeat (1 + 22 * D + 1) tick();
    check_val("mid_pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    check_val("mid_rst_async", 32'({tx, busy, done}), 32'h4);
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check_val("mid_post_rst", 32'({tx, busy, done, addr}), 32'h80);
    check_val("mid_no_done", done_cnt - d0, 0);
    $display("reset mid-frame: line idle, no done");

    // Fresh dump from address 0, then a back-to-back restart on the done cycle.
    rx_q.delete();
    d0 = done_cnt;
    rx_err = 0;
    pulse_start();
    check_val("b2b_first_addr", 32'({busy, addr}), 32'h20);
    wait_idle(6000, n);
    check_val("b2b_first_len", n, 5152);
    check_val("b2b_first_done", done, 1);
    check_sweep("b2b_first", exp_word(3));
    first_q = rx_q;
    rx_q.delete();
    pulse_start();
    check_val("b2b_load", 32'({busy, done, addr}), 32'h40);
    wait_idle(6000, n);
    check_val("b2b_second_len", n, 5152);
    tick();
    check_val("b2b_second_nbytes", rx_q.size(), 128);
    diffs = 0;
    for (int i = 0; i < 128; i++)
      if (i >= rx_q.size() || rx_q[i] !== first_q[i]) diffs++;
    check_val("b2b_stream_diffs", diffs, 0);
    check_val("b2b_done_cnt", done_cnt - d0, 2);
    check_val("bit_width_err", rx_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
